// File: rtl/icmp_echo_filter.sv
// Ingress classifier: buffers the IPv4 + first ICMP header words of each packet and
// forwards only well-formed ICMP Echo Requests that fit the reply stage; drops and counts the rest.
module icmp_echo_filter #(
  parameter  int MAX_WORDS = 32,
  localparam int HDR_WORDS = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] stream_in_data,
  input  logic [1:0]  stream_in_empty,
  input  logic        stream_in_valid,
  input  logic        stream_in_startofpacket,
  input  logic        stream_in_endofpacket,
  output logic        stream_in_ready,
  output logic [31:0] stream_out_data,
  output logic [1:0]  stream_out_empty,
  output logic        stream_out_valid,
  output logic        stream_out_startofpacket,
  output logic        stream_out_endofpacket,
  input  logic        stream_out_ready,
  output logic [15:0] accept_count,
  output logic [15:0] drop_count
);

  localparam logic [16:0] MAX_BYTES = 17'(MAX_WORDS * 4);
  localparam logic [2:0]  LAST_HDR  = 3'(HDR_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, DECIDE, FWD_HDR, FWD_BODY, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic        eop_seen_q, eop_seen_d;
  logic [1:0]  empty_saved_q, empty_saved_d;
  logic        ready_en_q;
  logic        out_valid_q, out_valid_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_empty_q, out_empty_d;
  logic [15:0] accept_q, accept_d;
  logic [15:0] drop_q, drop_d;

  logic [31:0] hdr_buf [HDR_WORDS];
  logic        buf_we;
  logic [2:0]  buf_idx;

  logic        in_fire, out_fire, body_pass, pass;
  logic [2:0]  tx_next;
  logic [7:0]  ver_ihl, protocol, icmp_type;
  logic [15:0] total_len;

  assign ver_ihl   = hdr_buf[0][7:0];
  assign total_len = {hdr_buf[0][23:16], hdr_buf[0][31:24]};
  assign protocol  = hdr_buf[2][15:8];
  assign icmp_type = hdr_buf[5][7:0];
  assign pass = (ver_ihl == 8'h45) && (protocol == 8'h01) && (icmp_type == 8'h08) &&
                ({1'b0, total_len} <= MAX_BYTES) && (total_len >= 16'd24);

  assign body_pass = (state_q == FWD_BODY);
  assign tx_next   = tx_cnt_q + 3'd1;

  // ready_en_q keeps the input closed until the first clock after reset release
  always_comb begin
    case (state_q)
      IDLE, HDR, DROP: stream_in_ready = ready_en_q;
      FWD_BODY:        stream_in_ready = stream_out_ready;
      default:         stream_in_ready = 1'b0;
    endcase
  end

  // Body words bypass the registers; header words come from the output registers
  assign stream_out_valid         = body_pass ? stream_in_valid : out_valid_q;
  assign stream_out_data          = body_pass ? stream_in_data : out_data_q;
  assign stream_out_empty         = body_pass ? (stream_in_endofpacket ? stream_in_empty : 2'd0)
                                              : out_empty_q;
  assign stream_out_startofpacket = body_pass ? 1'b0 : out_sop_q;
  assign stream_out_endofpacket   = body_pass ? stream_in_endofpacket : out_eop_q;
  assign accept_count             = accept_q;
  assign drop_count               = drop_q;

  assign in_fire  = stream_in_valid && stream_in_ready;
  assign out_fire = stream_out_valid && stream_out_ready;

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    eop_seen_d    = eop_seen_q;
    empty_saved_d = empty_saved_q;
    out_valid_d   = out_valid_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_data_d    = out_data_q;
    out_empty_d   = out_empty_q;
    accept_d      = accept_q;
    drop_d        = drop_q;
    buf_we        = 1'b0;
    buf_idx       = hdr_cnt_q;

    case (state_q)
      IDLE: begin
        if (in_fire && stream_in_startofpacket) begin
          if (stream_in_endofpacket) begin
            drop_d = drop_q + 16'd1;
          end else begin
            buf_we    = 1'b1;
            buf_idx   = 3'd0;
            hdr_cnt_d = 3'd1;
            state_d   = HDR;
          end
        end
      end
      HDR: begin
        if (in_fire) begin
          buf_we = 1'b1;
          if (hdr_cnt_q == LAST_HDR) begin
            eop_seen_d    = stream_in_endofpacket;
            empty_saved_d = stream_in_empty;
            state_d       = DECIDE;
          end else if (stream_in_endofpacket) begin
            drop_d  = drop_q + 16'd1;
            state_d = IDLE;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end
      DECIDE: begin
        if (pass) begin
          accept_d    = accept_q + 16'd1;
          tx_cnt_d    = 3'd0;
          out_valid_d = 1'b1;
          out_data_d  = hdr_buf[0];
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          out_empty_d = 2'd0;
          state_d     = FWD_HDR;
        end else begin
          drop_d  = drop_q + 16'd1;
          state_d = eop_seen_q ? IDLE : DROP;
        end
      end
      FWD_HDR: begin
        if (out_fire) begin
          if (tx_cnt_q == LAST_HDR) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_data_d  = 32'd0;
            out_empty_d = 2'd0;
            state_d     = eop_seen_q ? IDLE : FWD_BODY;
          end else begin
            tx_cnt_d    = tx_next;
            out_data_d  = hdr_buf[tx_next];
            out_sop_d   = 1'b0;
            out_eop_d   = (tx_next == LAST_HDR) && eop_seen_q;
            out_empty_d = ((tx_next == LAST_HDR) && eop_seen_q) ? empty_saved_q : 2'd0;
          end
        end
      end
      FWD_BODY, DROP: begin
        if (in_fire && stream_in_endofpacket) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hdr_cnt_q     <= 3'd0;
      tx_cnt_q      <= 3'd0;
      eop_seen_q    <= 1'b0;
      empty_saved_q <= 2'd0;
      ready_en_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_data_q    <= 32'd0;
      out_empty_q   <= 2'd0;
      accept_q      <= 16'd0;
      drop_q        <= 16'd0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      eop_seen_q    <= eop_seen_d;
      empty_saved_q <= empty_saved_d;
      ready_en_q    <= 1'b1;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_data_q    <= out_data_d;
      out_empty_q   <= out_empty_d;
      accept_q      <= accept_d;
      drop_q        <= drop_d;
    end
  end

  // Header storage carries no reset: contents are only read after being written
  always_ff @(posedge clk) begin
    if (buf_we) hdr_buf[buf_idx] <= stream_in_data;
  end

endmodule

// File: tb/tb_icmp_echo_filter.sv
// Scoreboard bench for icmp_echo_filter: expected output words are queued as packets
// are driven and checked as the filter emits them.
module tb_icmp_echo_filter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_empty = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic        out_valid, out_sop, out_eop;
  logic        out_ready = 1'b1;
  logic [15:0] accept_count, drop_count;

  icmp_echo_filter #(.MAX_WORDS(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .stream_in_data(in_data), .stream_in_empty(in_empty), .stream_in_valid(in_valid),
    .stream_in_startofpacket(in_sop), .stream_in_endofpacket(in_eop), .stream_in_ready(in_ready),
    .stream_out_data(out_data), .stream_out_empty(out_empty), .stream_out_valid(out_valid),
    .stream_out_startofpacket(out_sop), .stream_out_endofpacket(out_eop),
    .stream_out_ready(out_ready), .accept_count(accept_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       sb[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          stalls = 0;
  int          last_fire_cyc = 0, hdr6_cyc = 0, last_sop_cyc = 0;
  bit          abort = 1'b0;
  logic [15:0] exp_acc = 0, exp_drop = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1 out_ready = (ready_mode == 0) ? 1'b1 : ~out_ready;
  end

  // Output monitor: pops the scoreboard on every output transfer, checks stall stability
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    beat_t got, exp;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        got = {out_data, out_empty, out_sop, out_eop};
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %h expected no output", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL out_word: got data=%h empty=%0d sop=%b eop=%b expected data=%h empty=%0d sop=%b eop=%b",
                     got.data, got.empty, got.sop, got.eop, exp.data, exp.empty, exp.sop, exp.eop);
          end
        end
        if (out_sop) last_sop_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send_word(input beat_t b, input int gap_max);
    int waited = 0;
    if (gap_max > 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1; in_data = b.data; in_empty = b.empty; in_sop = b.sop; in_eop = b.eop;
    forever begin
      @(negedge clk);
      if (abort) break;
      if (in_ready) begin
        last_fire_cyc = cyc;
        break;
      end
      stalls++;
      waited++;
      if (waited > 500) begin
        n_vec++; n_err++;
        $display("FAIL in_ready_timeout: got ready=0 for %0d cycles expected ready", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input int nbytes, input logic [7:0] ver, input logic [7:0] proto,
                             input logic [7:0] icmp, input logic [15:0] tlen,
                             input bit exp_pass, input int gap_max);
    int nw = (nbytes + 3) / 4;
    logic [31:0] w;
    beat_t b;
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      if (i == 0) w = {tlen[7:0], tlen[15:8], w[15:8], ver};
      if (i == 2) w[15:8] = proto;
      if (i == 5) w[7:0] = icmp;
      b.data  = w;
      b.sop   = (i == 0);
      b.eop   = (i == nw - 1);
      b.empty = b.eop ? 2'(nw * 4 - nbytes) : 2'd0;
      if (exp_pass) sb.push_back(b);
      if (abort) break;
      send_word(b, gap_max);
      if (i == 5) hdr6_cyc = last_fire_cyc;
    end
    if (exp_pass) exp_acc++;
    else exp_drop++;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d words pending expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({in_ready, out_valid, out_sop, out_eop, out_data, out_empty} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b v=%b sop=%b eop=%b data=%h empty=%0d expected all 0",
               in_ready, out_valid, out_sop, out_eop, out_data, out_empty);
    end
    n_vec++;
    if (accept_count !== 16'd0 || drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_counters: got acc=%0d drop=%0d expected 0 0", accept_count, drop_count);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_echo();
    send_packet(84, 8'h45, 8'h01, 8'h08, 16'd84, 1'b1, 0);
    wait_drain("echo84");
    n_vec++;
    if (last_sop_cyc - hdr6_cyc != 2) begin
      n_err++;
      $display("FAIL echo_latency: got %0d cycles expected 2", last_sop_cyc - hdr6_cyc);
    end
    n_vec++;
    if (accept_count !== exp_acc) begin
      n_err++;
      $display("FAIL echo_accept: got %0d expected %0d", accept_count, exp_acc);
    end
  endtask

  task automatic test_udp_then_echo();
    stalls = 0;
    send_packet(40, 8'h45, 8'h11, 8'h08, 16'd40, 1'b0, 0);
    n_vec++;
    if (stalls != 1) begin
      n_err++;
      $display("FAIL udp_ready: got %0d stall cycles expected 1", stalls);
    end
    wait_drain("udp");
    n_vec++;
    if (drop_count !== exp_drop) begin
      n_err++;
      $display("FAIL udp_drop: got %0d expected %0d", drop_count, exp_drop);
    end
    send_packet(64, 8'h45, 8'h01, 8'h08, 16'd64, 1'b1, 0);
    wait_drain("after_udp");
    n_vec++;
    if (accept_count !== exp_acc) begin
      n_err++;
      $display("FAIL after_udp_accept: got %0d expected %0d", accept_count, exp_acc);
    end
  endtask

  task automatic test_bad_headers();
    send_packet(84, 8'h45, 8'h01, 8'h00, 16'd84, 1'b0, 0);
    send_packet(84, 8'h46, 8'h01, 8'h08, 16'd84, 1'b0, 0);
    wait_drain("bad_hdr");
    n_vec++;
    if (drop_count !== exp_drop || accept_count !== exp_acc) begin
      n_err++;
      $display("FAIL bad_hdr_counts: got acc=%0d drop=%0d expected acc=%0d drop=%0d",
               accept_count, drop_count, exp_acc, exp_drop);
    end
  endtask

  task automatic test_length_limits();
    beat_t stray;
    stray = {32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0};
    send_word(stray, 0);
    send_packet(4, 8'h45, 8'h01, 8'h08, 16'd4, 1'b0, 0);
    wait_drain("short");
    n_vec++;
    if (drop_count !== exp_drop) begin
      n_err++;
      $display("FAIL stray_and_1word: got drop=%0d expected %0d", drop_count, exp_drop);
    end
    send_packet(132, 8'h45, 8'h01, 8'h08, 16'd132, 1'b0, 0);
    send_packet(128, 8'h45, 8'h01, 8'h08, 16'd128, 1'b1, 0);
    wait_drain("len128");
    send_packet(24, 8'h45, 8'h01, 8'h08, 16'd24, 1'b1, 0);
    wait_drain("len24");
    send_packet(20, 8'h45, 8'h01, 8'h08, 16'd20, 1'b0, 0);
    send_packet(28, 8'h45, 8'h01, 8'h08, 16'd23, 1'b0, 0);
    wait_drain("len_drop");
    n_vec++;
    if (drop_count !== exp_drop || accept_count !== exp_acc) begin
      n_err++;
      $display("FAIL length_counts: got acc=%0d drop=%0d expected acc=%0d drop=%0d",
               accept_count, drop_count, exp_acc, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    ready_mode = 1;
    send_packet(102, 8'h45, 8'h01, 8'h08, 16'd102, 1'b1, 2);
    send_packet(60, 8'h45, 8'h01, 8'h08, 16'd60, 1'b1, 2);
    send_packet(40, 8'h45, 8'h06, 8'h08, 16'd40, 1'b0, 2);
    send_packet(33, 8'h45, 8'h01, 8'h08, 16'd33, 1'b1, 1);
    wait_drain("backpressure");
    ready_mode = 0;
    n_vec++;
    if (drop_count !== exp_drop || accept_count !== exp_acc) begin
      n_err++;
      $display("FAIL backpressure_counts: got acc=%0d drop=%0d expected acc=%0d drop=%0d",
               accept_count, drop_count, exp_acc, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    fork
      send_packet(128, 8'h45, 8'h01, 8'h08, 16'd128, 1'b1, 0);
      begin
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        abort = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_sop, out_eop, out_data, out_empty} !== '0) begin
          n_err++;
          $display("FAIL midreset_outputs: got rdy=%b v=%b sop=%b eop=%b data=%h expected all 0",
                   in_ready, out_valid, out_sop, out_eop, out_data);
        end
        n_vec++;
        if (accept_count !== 16'd0 || drop_count !== 16'd0) begin
          n_err++;
          $display("FAIL midreset_counters: got acc=%0d drop=%0d expected 0 0",
                   accept_count, drop_count);
        end
      end
    join
    sb.delete();
    abort = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_acc = 0;
    exp_drop = 0;
    @(posedge clk);
    #1;
    send_packet(48, 8'h45, 8'h01, 8'h08, 16'd48, 1'b1, 0);
    wait_drain("post_reset");
    n_vec++;
    if (accept_count !== 16'd1 || drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL post_reset_counts: got acc=%0d drop=%0d expected 1 0", accept_count, drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_udp_then_echo();
    test_bad_headers();
    test_length_limits();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule
